seg_display_bank: RTL and testbench

//   Parametrised, registered driver for a bank of active-low 7-segment hex digits.

---
 rtl/seg_display_bank.sv | 122 ++++++++++++
 tb/tb_seg_display_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_bank.sv
`default_nettype none
// ============================================================================
// seg_display_bank : registered active-low 7-segment bank with hold/blink/LZS
// Revision: 1.0
// ============================================================================
module seg_display_bank #(
  parameter int NUM_DIGITS = 6,
  parameter int HOLD_CYC   = 8,
  parameter int BLINK_DIV  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    active,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    showing
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC > 0 ? HOLD_CYC - 1 : 0);
  localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                    state;
  logic [4*NUM_DIGITS-1:0]   val_q;
  logic [HW-1:0]             hold_cnt;
  logic [BW-1:0]             blink_cnt;
  logic                      blink_ph;
  logic [NUM_DIGITS-1:0]     lz_blank;
  logic                      lead;
  logic [7*NUM_DIGITS-1:0]   seg_d;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  // Leading zeros are blanked from the top digit down until the first nonzero
  // nibble; digit 0 always stays visible so a zero value shows a single "0".
  always_comb begin
    lz_blank = '0;
    lead     = lz_en;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (val_q[4*i +: 4] != 4'h0) lead = 1'b0;
      lz_blank[i] = lead && (i != 0);
    end
  end

  always_comb begin
    seg_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (state == IDLE || (blink_mask[i] && blink_ph) || lz_blank[i])
        seg_d[7*i +: 7] = 7'h7F;
      else
        seg_d[7*i +: 7] = glyph(val_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      val_q     <= '0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      seg       <= '1;
      showing   <= 1'b0;
    end else begin
      if (load) val_q <= value;

      if (blink_cnt == BLINK_TOP) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      // Outputs reflect the state and captured value from before this edge.
      seg     <= seg_d;
      showing <= (state != IDLE);

      case (state)
        IDLE: if (active) state <= SHOW;
        SHOW: begin
          if (!active) begin
            if (HOLD_CYC > 0) begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (active)                state    <= SHOW;
          else if (hold_cnt == '0)   state    <= IDLE;
          else                       hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_bank.sv
`default_nettype none
// tb_seg_display_bank : scoreboard-checked directed test of seg_display_bank
module tb_seg_display_bank;

  logic        clk = 1'b0;
  logic        rst, load, active, lz_en;
  logic [23:0] value;
  logic [5:0]  blink_mask;
  logic [41:0] seg;
  logic        showing;

  int checks = 0;
  int errors = 0;

  typedef logic [42:0] exp_t;
  exp_t sb[$];

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  int          m_state = 0;   // 0 idle, 1 show, 2 hold
  int          m_hold  = 0;
  logic [23:0] m_val   = '0;
  int          m_bcnt  = 0;
  logic        m_bph   = 1'b0;

  seg_display_bank #(.NUM_DIGITS(6), .HOLD_CYC(8), .BLINK_DIV(16)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .active(active),
    .blink_mask(blink_mask), .lz_en(lz_en), .seg(seg), .showing(showing)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] model_seg();
    logic [41:0] s;
    int msd;
    msd = 0;
    for (int i = 0; i < 6; i++)
      if (m_val[4*i +: 4] != 4'h0) msd = i;
    s = '1;
    if (m_state != 0) begin
      for (int i = 0; i < 6; i++) begin
        if (blink_mask[i] && m_bph)  s[7*i +: 7] = 7'h7F;
        else if (lz_en && i > msd)   s[7*i +: 7] = 7'h7F;
        else                         s[7*i +: 7] = glyph_tab[m_val[4*i +: 4]];
      end
    end
    return s;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_state = 0; m_hold = 0; m_val = '0; m_bcnt = 0; m_bph = 1'b0;
    end else begin
      if (load) m_val = value;
      if (m_bcnt == 15) begin m_bcnt = 0; m_bph = ~m_bph; end
      else m_bcnt++;
      case (m_state)
        0: if (active) m_state = 1;
        1: if (!active) begin m_state = 2; m_hold = 7; end
        default: begin
          if (active)           m_state = 1;
          else if (m_hold == 0) m_state = 0;
          else                  m_hold--;
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    if (rst) e = {1'b0, {42{1'b1}}};
    else     e = {(m_state != 0), model_seg()};
    sb.push_back(e);
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_seg", 64'(seg), 64'(e[41:0]));
    chk("sb_showing", 64'(showing), 64'(e[42]));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  localparam logic [41:0] LIT_12AF = {7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h0E};
  localparam logic [34:0] LIT_HI   = {7'h40, 7'h40, 7'h79, 7'h24, 7'h08};

  int lit;
  int blanks;
  int unsteady;

  initial begin
    rst = 1'b1; load = 1'b0; active = 1'b1; lz_en = 1'b0;
    value = '0; blink_mask = '0;

    // reset with active held high
    ticks(2);
    chk("reset_seg", 64'(seg), 64'(42'h3FF_FFFF_FFFF));
    chk("reset_showing", 64'(showing), 64'd0);
    rst = 1'b0;

    // load + active: digits appear two edges later
    load = 1'b1; value = 24'h0012AF;
    tick();
    load = 1'b0;
    tick();
    chk("load_digits", 64'(seg), 64'(LIT_12AF));
    chk("load_showing", 64'(showing), 64'd1);

    lz_en = 1'b1;
    tick();
    chk("lz_digits", 64'(seg), 64'({7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08, 7'h0E}));

    load = 1'b1; value = 24'h000000;
    tick();
    load = 1'b0;
    tick();
    chk("lz_zero", 64'(seg), 64'({{5{7'h7F}}, 7'h40}));

    lz_en = 1'b0; load = 1'b1; value = 24'h0012AF;
    tick();
    load = 1'b0;
    ticks(2);
    chk("relit", 64'(seg), 64'(LIT_12AF));

    // release: one pipeline edge from SHOW plus eight HOLD cycles stay lit
    active = 1'b0;
    lit = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (showing && seg == LIT_12AF) lit++;
    end
    chk("hold_len", 64'(lit), 64'd9);
    chk("hold_blank", 64'(seg), 64'(42'h3FF_FFFF_FFFF));

    // retrigger during hold, then a full window again
    active = 1'b1;
    ticks(3);
    active = 1'b0;
    ticks(5);
    chk("retrig_lit", 64'(seg), 64'(LIT_12AF));
    active = 1'b1;
    ticks(3);
    active = 1'b0;
    lit = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (showing && seg == LIT_12AF) lit++;
    end
    chk("retrig_hold_len", 64'(lit), 64'd9);

    // blink digit 0: half of any two full periods is blank
    active = 1'b1; blink_mask = 6'b000001;
    ticks(2);
    blanks = 0; unsteady = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (seg[6:0] == 7'h7F) blanks++;
      else if (seg[6:0] != 7'h0E) unsteady++;
      if (seg[41:7] != LIT_HI) unsteady++;
    end
    chk("blink_blanks", 64'(blanks), 64'd32);
    chk("blink_steady", 64'(unsteady), 64'd0);
    blink_mask = '0;

    // reset while holding blanks at once
    ticks(2);
    active = 1'b0;
    ticks(3);
    chk("pre_rst_showing", 64'(showing), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_hold_seg", 64'(seg), 64'(42'h3FF_FFFF_FFFF));
    chk("rst_hold_showing", 64'(showing), 64'd0);
    rst = 1'b0;

    // load while inactive stays blank until active
    load = 1'b1; value = 24'h00C0DE;
    tick();
    load = 1'b0;
    ticks(3);
    chk("idle_load_blank", 64'(seg), 64'(42'h3FF_FFFF_FFFF));
    active = 1'b1;
    ticks(2);
    chk("idle_load_lit", 64'(seg), 64'({7'h40, 7'h40, 7'h46, 7'h40, 7'h21, 7'h06}));
    ticks(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
